// File: rtl/fir_sine_src.sv
// fir_sine_src: 8-phase signed sine test-tone source driving fir (i_fir_data/i_en_buff/i_en_fir).
// Optional macro FIR_SRC_AMP_EN adds i_amp_shift, an arithmetic attenuation applied per new sample.
module fir_sine_src #(
    parameter int DATA_W = 16,
    parameter int HOLD_W = 5
) (
    input  logic              i_clk_tb,
    input  logic              i_rst_n_tb,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [HOLD_W-1:0] i_hold,
`ifdef FIR_SRC_AMP_EN
    input  logic [1:0]        i_amp_shift,
`endif
    output logic [DATA_W-1:0] o_fir_data,
    output logic              o_en_buff,
    output logic              o_en_fir,
    output logic              o_sample_stb,
    output logic [2:0]        o_phase,
    output logic              o_busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRIME    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_STOPPING = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              stb_q,   stb_d;
    logic              en_q,    en_d;
    logic              busy_q,  busy_d;

    logic [2:0]               sample_phase;
    logic [15:0]              lut_word;
    logic signed [DATA_W-1:0] full_scale;
    logic signed [DATA_W-1:0] new_sample;
    logic                     last_hold;
    logic                     period_end;

    function automatic logic [15:0] lut_value(input logic [2:0] phase);
        case (phase)
            3'd0:    lut_value = 16'h0000;
            3'd1:    lut_value = 16'h5A7E;
            3'd2:    lut_value = 16'h7FFF;
            3'd3:    lut_value = 16'h5A7E;
            3'd4:    lut_value = 16'h0000;
            3'd5:    lut_value = 16'hA582;
            3'd6:    lut_value = 16'h8000;
            default: lut_value = 16'hA582;
        endcase
    endfunction

    // The sample loaded next is LUT[0] on leaving PRIME, otherwise the following phase.
    assign sample_phase = (state_q == ST_PRIME) ? 3'd0 : phase_q + 3'd1;
    assign lut_word     = lut_value(sample_phase);
    assign full_scale   = DATA_W'($signed(lut_word));
`ifdef FIR_SRC_AMP_EN
    assign new_sample   = full_scale >>> i_amp_shift;
`else
    assign new_sample   = full_scale;
`endif

    assign last_hold  = (cnt_q == hold_q);
    assign period_end = last_hold && (phase_q == 3'd7);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        en_d    = en_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                phase_d = 3'd0;
                cnt_d   = '0;
                data_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                // Start wins over a simultaneous stop; stop alone is meaningless here.
                if (i_start) begin
                    state_d = ST_PRIME;
                    hold_d  = i_hold;
                    busy_d  = 1'b1;
                end
            end

            ST_PRIME: begin
                state_d = ST_RUN;
                phase_d = 3'd0;
                cnt_d   = '0;
                data_d  = new_sample;
                stb_d   = 1'b1;
                en_d    = 1'b1;
                busy_d  = 1'b1;
            end

            ST_RUN, ST_STOPPING: begin
                if (i_stop) begin
                    state_d = ST_STOPPING;
                end
                if (last_hold) begin
                    cnt_d = '0;
                    // A stop seen on the very last cycle of phase 7 still ends at this wrap.
                    if (period_end && ((state_q == ST_STOPPING) || i_stop)) begin
                        state_d = ST_IDLE;
                        phase_d = 3'd0;
                        data_d  = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        phase_d = sample_phase;
                        data_d  = new_sample;
                        stb_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = 3'd0;
                cnt_d   = '0;
                data_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_tb or negedge i_rst_n_tb) begin
        if (!i_rst_n_tb) begin
            state_q <= ST_IDLE;
            phase_q <= 3'd0;
            cnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign o_fir_data   = data_q;
    assign o_en_buff    = en_q;
    assign o_en_fir     = en_q;
    assign o_sample_stb = stb_q;
    assign o_phase      = phase_q;
    assign o_busy       = busy_q;

endmodule
